// File: rtl/siso_ctrl_pkg.sv
// siso_ctrl_pkg
// Shared types and helpers for the SISO shift-register sequencer.
//   state_t       : controller state encoding (IDLE, SHIFT, PAR, DONE)
//   DEFAULT_WIDTH : default bits per frame
//   DEFAULT_DIV   : default clocks per serial bit
//   even_parity() : even parity of a word, zero-extended to PARITY_MAX_W bits
package siso_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_DIV   = 1;

    // Callers zero-extend their word to this width; extra zero bits leave the
    // parity unchanged.
    localparam int PARITY_MAX_W = 64;

    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/siso_bit_timer.sv
// siso_bit_timer
// Bit-period divider: counts DIV clocks per serial bit while running and
// flags the last clock of each bit period.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   run  : count while high
//   clr  : synchronous counter clear (dominates run)
//   tick : high in the final clock of each bit period (shift strobe source)
module siso_bit_timer
    import siso_ctrl_pkg::*;
#(
    parameter int DIV = DEFAULT_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] div_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            div_cnt <= '0;
        end else if (run) begin
            div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + 1'b1;
        end
    end

    // run comes from the controller's state register, so tick never depends
    // combinationally on a module input of the controller.
    assign tick = run && (div_cnt == LAST);

endmodule

// File: rtl/siso_shift_ctrl.sv
// siso_shift_ctrl
// Serializes a parallel word onto the din of a downstream SISO register,
// holding each bit for DIV clocks and strobing shift_en once per bit.
// Optional feature: define SISO_SHIFT_CTRL_PARITY_EN to append an even-parity
// bit after the data bits.
// Ports:
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   load_valid : producer has a word
//   load_ready : controller can accept a word (0 while rst is high)
//   load_data  : word to serialize
//   abort      : synchronous frame cancel
//   sout       : serial bit to downstream din
//   shift_en   : one-cycle strobe, downstream samples sout when high
//   busy       : frame in progress
//   done       : one-cycle pulse at frame completion
module siso_shift_ctrl
    import siso_ctrl_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int DIV       = DEFAULT_DIV,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             abort,
    output logic             sout,
    output logic             shift_en,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam int OUT_IDX = MSB_FIRST ? WIDTH - 1 : 0;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shadow;
    logic [BW-1:0]    bit_cnt;
    logic             tick;
    logic             run;
    logic             accept;

`ifdef SISO_SHIFT_CTRL_PARITY_EN
    logic par_bit;
    assign run = (state == SHIFT) || (state == PAR);
`else
    assign run = (state == SHIFT);
`endif

    siso_bit_timer #(.DIV(DIV)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .clr  (!run),
        .tick (tick)
    );

    assign load_ready = (state == IDLE) && !rst;
    assign accept     = load_valid && load_ready;

    // Every output below is decoded purely from flops (state, shadow, timer
    // counter), so no input reaches sout/shift_en/busy/done combinationally.
    assign shift_en = tick;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    always_comb begin
        sout = 1'b0;
        if (state == SHIFT) begin
            sout = shadow[OUT_IDX];
        end
`ifdef SISO_SHIFT_CTRL_PARITY_EN
        else if (state == PAR) begin
            sout = par_bit;
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (tick && (bit_cnt == LAST_BIT)) begin
`ifdef SISO_SHIFT_CTRL_PARITY_EN
                    state_nxt = PAR;
`else
                    state_nxt = DONE;
`endif
                end
            end
`ifdef SISO_SHIFT_CTRL_PARITY_EN
            PAR: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (tick) begin
                    state_nxt = DONE;
                end
            end
`endif
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The shadow register shifts toward the output bit position so the bit
    // currently on sout always sits at OUT_IDX.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shadow  <= '0;
            bit_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                shadow  <= load_data;
                bit_cnt <= '0;
            end else if ((state == SHIFT) && tick) begin
                shadow  <= MSB_FIRST ? (shadow << 1) : (shadow >> 1);
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

`ifdef SISO_SHIFT_CTRL_PARITY_EN
    // Parity is taken at capture time because the shadow register is
    // consumed by shifting.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_bit <= 1'b0;
        end else if (accept) begin
            par_bit <= even_parity(PARITY_MAX_W'(load_data));
        end
    end
`endif

endmodule

// File: tb/tb_siso_shift_ctrl.sv
// tb_siso_shift_ctrl
// Directed bench for siso_shift_ctrl: instance dut_a (WIDTH=4, DIV=1,
// MSB first) and instance dut_b (WIDTH=4, DIV=3, LSB first).
// Honors SISO_SHIFT_CTRL_PARITY_EN for the expected frame length.
module tb_siso_shift_ctrl;

`ifdef SISO_SHIFT_CTRL_PARITY_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       load_valid;
    logic [3:0] load_data;
    logic       abort;
    logic       sel;

    logic ready_a, sout_a, se_a, busy_a, done_a;
    logic ready_b, sout_b, se_b, busy_b, done_b;

    logic obs_ready, obs_sout, obs_se, obs_busy, obs_done;

    int checks = 0;
    int errors = 0;

    logic [3:0] chain;
    logic [3:0] chain4;
    int         strobe_cnt;

    always #5 clk = ~clk;

    siso_shift_ctrl #(.WIDTH(4), .DIV(1), .MSB_FIRST(1'b1)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid && !sel),
        .load_ready (ready_a),
        .load_data  (load_data),
        .abort      (abort && !sel),
        .sout       (sout_a),
        .shift_en   (se_a),
        .busy       (busy_a),
        .done       (done_a)
    );

    siso_shift_ctrl #(.WIDTH(4), .DIV(3), .MSB_FIRST(1'b0)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid && sel),
        .load_ready (ready_b),
        .load_data  (load_data),
        .abort      (abort && sel),
        .sout       (sout_b),
        .shift_en   (se_b),
        .busy       (busy_b),
        .done       (done_b)
    );

    assign obs_ready = sel ? ready_b : ready_a;
    assign obs_sout  = sel ? sout_b  : sout_a;
    assign obs_se    = sel ? se_b    : se_a;
    assign obs_busy  = sel ? busy_b  : busy_a;
    assign obs_done  = sel ? done_b  : done_a;

    // Downstream 4-bit SISO register chained to dut_a; chain4 snapshots its
    // contents at the 4th strobe of a frame.
    always @(posedge clk) begin
        if (rst) begin
            chain      <= 4'b0;
            chain4     <= 4'b0;
            strobe_cnt <= 0;
        end else if (se_a) begin
            chain      <= {chain[2:0], sout_a};
            strobe_cnt <= strobe_cnt + 1;
            if (strobe_cnt == 3) begin
                chain4 <= {chain[2:0], sout_a};
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] d, input logic ab, input logic r);
        load_valid = v;
        load_data  = d;
        abort      = ab;
        rst        = r;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdle(input string tag, input logic rdy);
        checkOutput({tag, "_sout"}, 32'(obs_sout), 32'd0);
        checkOutput({tag, "_se"},   32'(obs_se),   32'd0);
        checkOutput({tag, "_busy"}, 32'(obs_busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(obs_done), 32'd0);
        checkOutput({tag, "_rdy"},  32'(obs_ready), 32'(rdy));
    endtask

    // seq holds the hand-computed bit order on sout, first bit at seq[4];
    // seq[0] is the parity bit used only when the feature is built in.
    task automatic runFrame(input string tag, input logic use_b, input logic [3:0] data,
                            input logic [4:0] seq, input int div, input logic hold);
        sel = use_b;
        #1;
        checkOutput({tag, "_rdy_start"}, 32'(obs_ready), 32'd1);
        applyStimulus(1'b1, data, 1'b0, 1'b0);
        stepCycle();
        if (hold) load_data = 4'hF;
        else      load_valid = 1'b0;
        for (int c = 1; c <= NB * div; c++) begin
            checkOutput($sformatf("%s_sout_c%0d", tag, c), 32'(obs_sout), 32'(seq[4 - (c - 1) / div]));
            checkOutput($sformatf("%s_se_c%0d", tag, c), 32'(obs_se), 32'((c % div) == 0));
            checkOutput($sformatf("%s_busy_c%0d", tag, c), 32'(obs_busy), 32'd1);
            checkOutput($sformatf("%s_done_c%0d", tag, c), 32'(obs_done), 32'd0);
            checkOutput($sformatf("%s_rdy_c%0d", tag, c), 32'(obs_ready), 32'd0);
            stepCycle();
        end
        checkOutput({tag, "_done"},      32'(obs_done),  32'd1);
        checkOutput({tag, "_done_busy"}, 32'(obs_busy),  32'd1);
        checkOutput({tag, "_done_sout"}, 32'(obs_sout),  32'd0);
        checkOutput({tag, "_done_se"},   32'(obs_se),    32'd0);
        checkOutput({tag, "_done_rdy"},  32'(obs_ready), 32'd0);
        stepCycle();
        checkOutput({tag, "_after_rdy"},  32'(obs_ready), 32'd1);
        checkOutput({tag, "_after_busy"}, 32'(obs_busy),  32'd0);
        checkOutput({tag, "_after_done"}, 32'(obs_done),  32'd0);
    endtask

    initial begin
        sel = 1'b0;
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
        stepCycle();
        stepCycle();
        $display("[TB] reset state");
        checkIdle("rst_a", 1'b0);
        sel = 1'b1;
        #1;
        checkIdle("rst_b", 1'b0);
        sel = 1'b0;
        rst = 1'b0;
        #1;
        checkOutput("rst_release_rdy", 32'(ready_a), 32'd1);

        $display("[TB] MSB-first 1011, DIV=1");
        runFrame("msb1011", 1'b0, 4'b1011, 5'b10111, 1, 1'b0);
        checkOutput("chain_after_4_strobes", 32'(chain4), 32'hB);

        $display("[TB] LSB-first 0110, DIV=3");
        runFrame("lsb0110", 1'b1, 4'b0110, 5'b01100, 3, 1'b0);

        $display("[TB] back-pressure 5 then F");
        runFrame("bp5", 1'b0, 4'h5, 5'b01010, 1, 1'b1);
        runFrame("bpF", 1'b0, 4'hF, 5'b11110, 1, 1'b0);

        $display("[TB] abort after 2nd strobe of 1100");
        sel = 1'b0;
        applyStimulus(1'b1, 4'b1100, 1'b0, 1'b0);
        stepCycle();
        load_valid = 1'b0;
        checkOutput("ab_sout_c1", 32'(sout_a), 32'd1);
        stepCycle();
        checkOutput("ab_sout_c2", 32'(sout_a), 32'd1);
        checkOutput("ab_se_c2",   32'(se_a),   32'd1);
        stepCycle();
        checkOutput("ab_sout_c3", 32'(sout_a), 32'd0);
        checkOutput("ab_busy_c3", 32'(busy_a), 32'd1);
        abort = 1'b1;
        stepCycle();
        abort = 1'b0;
        checkIdle("ab_c4", 1'b1);
        stepCycle();
        checkIdle("ab_c5", 1'b1);
        runFrame("ab_next1001", 1'b0, 4'b1001, 5'b10010, 1, 1'b0);

        $display("[TB] reset mid-frame with abort");
        applyStimulus(1'b1, 4'b1011, 1'b0, 1'b0);
        stepCycle();
        load_valid = 1'b0;
        checkOutput("rm_busy_c1", 32'(busy_a), 32'd1);
        stepCycle();
        rst   = 1'b1;
        abort = 1'b1;
        #1;
        checkOutput("rm_rdy_c2", 32'(ready_a), 32'd0);
        stepCycle();
        checkIdle("rm_c3", 1'b0);
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
        #1;
        checkOutput("rm_rdy_c3_released", 32'(ready_a), 32'd1);
        stepCycle();
        checkIdle("rm_c4", 1'b1);
        stepCycle();
        checkIdle("rm_c5", 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
